// File: rtl/timer.sv
// -----------------------------------------------------------------------------
// timer: memory-mapped down-counting timer with one-shot and auto-reload modes.
//
// Register map (addr):
//   00 CTRL   : bit0 EN, bits2:1 MODE (01 auto-reload, anything else one-shot),
//               bit3 IM (interrupt mask, 1 = IRQ visible); bits31:4 read 0
//   01 PRESET : reload value copied into COUNT on every LOAD
//   10 COUNT  : current count (read-only)
//   11 unused : reads 0, writes ignored
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   rst   - synchronous active-high reset, overrides any concurrent write
//   addr  - word select for both reads and writes
//   wen   - write strobe, sampled at the rising edge
//   din   - write data
//   dout  - combinational read data for addr
//   IRQ   - interrupt request (pending flag gated by CTRL.IM)
// -----------------------------------------------------------------------------
module timer (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        wen,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CNT  = 2'b10,
    INT  = 2'b11
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_q, irq_d;

  logic ctrl_en;
  logic ctrl_im;
  logic auto_reload;
  logic wr_ctrl;
  logic wr_preset;

  assign ctrl_en     = ctrl_q[0];
  assign ctrl_im     = ctrl_q[3];
  // Only MODE=01 reloads; 00, 10 and 11 all behave as one-shot.
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  assign wr_ctrl   = wen && (addr == ADDR_CTRL);
  assign wr_preset = wen && (addr == ADDR_PRESET);

  // Next-state logic. The FSM always evaluates the registered (pre-write)
  // values; software writes are applied afterwards so that a CTRL write wins
  // over the FSM clearing EN in the same cycle.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    irq_d    = irq_q;

    case (state_q)
      IDLE: begin
        if (ctrl_en) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Covers a preset of 0 as well as the normal terminal count of 1,
          // so the counter can never wrap below zero.
          count_d = '0;
          irq_d   = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (auto_reload) begin
          irq_d   = 1'b0;
          state_d = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Software acknowledge of a one-shot interrupt: a CTRL or PRESET write
    // clears the pending flag, but only while the request is actually visible
    // (IM=1). A write that merely raises IM therefore exposes a flag that was
    // pending under the mask instead of silently discarding it.
    if ((wr_ctrl || wr_preset) && irq_q && ctrl_im && !auto_reload) begin
      irq_d = 1'b0;
    end

    if (wr_ctrl) begin
      ctrl_d = din[3:0];
    end
    if (wr_preset) begin
      preset_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout = {28'b0, ctrl_q};
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
      default:     dout = '0;
    endcase
  end

  assign IRQ = irq_q & ctrl_im;

endmodule

// File: tb/tb_timer.sv
// -----------------------------------------------------------------------------
// tb_timer: self-checking bench for timer. Expected reads are queued per cycle
// (relative to the edge that sampled the triggering write) and compared as the
// cycles elapse; scheduled writes are replayed from the same queue.
// -----------------------------------------------------------------------------
module tb_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        wen;
  logic [31:0] din;
  logic [31:0] dout;
  logic        IRQ;

  timer dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .wen  (wen),
    .din  (din),
    .dout (dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  int    n_total = 0;
  int    n_fail  = 0;
  string cur_test = "init";

  typedef struct {
    int          key;   // 2*cycle + is_wr, so writes run after that cycle's reads
    bit          is_wr;
    logic [1:0]  a;
    logic [31:0] v;
    logic        irq;
  } item_t;

  item_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] v, input logic irq);
    addr = a;
    #1;
    check($sformatf("%s dout", tag), dout, v);
    check($sformatf("%s irq", tag), {31'b0, IRQ}, {31'b0, irq});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    wen  = 1'b1;
    tick();
  endtask

  task automatic push_item(input item_t it);
    int i;
    i = sb.size();
    while (i > 0 && sb[i-1].key > it.key) i--;
    sb.insert(i, it);
  endtask

  task automatic exp_rd(input int c, input logic [1:0] a, input logic [31:0] v, input logic irq);
    item_t it;
    it.key = 2 * c; it.is_wr = 1'b0; it.a = a; it.v = v; it.irq = irq;
    push_item(it);
  endtask

  task automatic sched_wr(input int c, input logic [1:0] a, input logic [31:0] d);
    item_t it;
    it.key = 2 * c + 1; it.is_wr = 1'b1; it.a = a; it.v = d; it.irq = 1'b0;
    push_item(it);
  endtask

  task automatic run(input int ncyc);
    item_t it;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      while (sb.size() > 0 && (sb[0].key >> 1) == c) begin
        it = sb.pop_front();
        if (it.is_wr) begin
          addr = it.a;
          din  = it.v;
          wen  = 1'b1;
        end else begin
          rd($sformatf("%s c%0d a%0d", cur_test, c, it.a), it.a, it.v, it.irq);
        end
      end
    end
    check($sformatf("%s leftover", cur_test), 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Reset held two cycles while a CTRL write of all ones is attempted.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      addr = 2'b00;
      din  = '1;
      wen  = 1'b1;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned rl [5];
    rl[0] = 3; rl[1] = 2; rl[2] = 1; rl[3] = 0; rl[4] = 0;
    rst = 1'b1; wen = 1'b0; addr = 2'b00; din = '0;

    // Reset values, write masking, unused/read-only addresses
    cur_test = "reset";
    do_reset();
    for (int a = 0; a < 4; a++) rd($sformatf("reset a%0d", a), 2'(a), 32'd0, 1'b0);
    wr(2'b11, 32'h1234_5678);
    wr(2'b10, 32'hDEAD_BEEF);
    rd("wr_unused a3", 2'b11, 32'd0, 1'b0);
    rd("wr_count a2", 2'b10, 32'd0, 1'b0);
    wr(2'b00, 32'hFFFF_FFF6);
    rd("ctrl_mask", 2'b00, 32'h6, 1'b0);

    // One-shot PRESET=5, acknowledge by CTRL write
    cur_test = "oneshot";
    do_reset();
    wr(2'b01, 32'd5);
    wr(2'b00, 32'h9);
    exp_rd(1, 2'b10, 32'd0, 1'b0);
    for (int k = 2; k <= 6; k++) exp_rd(k, 2'b10, 32'(7 - k), 1'b0);
    exp_rd(7, 2'b10, 32'd0, 1'b1);
    exp_rd(7, 2'b00, 32'h9, 1'b1);
    exp_rd(8, 2'b00, 32'h8, 1'b1);
    sched_wr(8, 2'b00, 32'h8);
    for (int c = 9; c <= 11; c++) exp_rd(c, 2'b00, 32'h8, 1'b0);
    run(11);

    // Masked flag stays pending, raising IM exposes it, PRESET write acks it
    cur_test = "masked";
    do_reset();
    wr(2'b01, 32'd2);
    wr(2'b00, 32'h1);
    exp_rd(4, 2'b10, 32'd0, 1'b0);
    exp_rd(5, 2'b00, 32'h0, 1'b0);
    sched_wr(6, 2'b00, 32'h8);
    exp_rd(7, 2'b00, 32'h8, 1'b1);
    exp_rd(8, 2'b00, 32'h8, 1'b1);
    sched_wr(8, 2'b01, 32'd2);
    exp_rd(9, 2'b00, 32'h8, 1'b0);
    exp_rd(10, 2'b00, 32'h8, 1'b0);
    run(10);

    // MODE=10 behaves as one-shot
    cur_test = "mode10";
    do_reset();
    wr(2'b01, 32'd2);
    wr(2'b00, 32'hD);
    exp_rd(4, 2'b00, 32'hD, 1'b1);
    for (int c = 5; c <= 8; c++) exp_rd(c, 2'b00, 32'hC, 1'b1);
    run(8);

    // Auto-reload PRESET=3: one-cycle IRQ every 5 cycles, 4 periods
    cur_test = "autoreload";
    do_reset();
    wr(2'b01, 32'd3);
    wr(2'b00, 32'hB);
    for (int c = 1; c <= 22; c++)
      exp_rd(c, 2'b10, (c == 1) ? 32'd0 : rl[(c - 2) % 5], (c >= 5) && (c % 5 == 0));
    run(22);

    // PRESET rewritten during CNT applies only at the next LOAD
    cur_test = "preset_cnt";
    do_reset();
    wr(2'b01, 32'd3);
    wr(2'b00, 32'hB);
    exp_rd(2, 2'b10, 32'd3, 1'b0);
    sched_wr(2, 2'b01, 32'd7);
    exp_rd(3, 2'b10, 32'd2, 1'b0);
    exp_rd(3, 2'b01, 32'd7, 1'b0);
    exp_rd(4, 2'b10, 32'd1, 1'b0);
    exp_rd(5, 2'b10, 32'd0, 1'b1);
    exp_rd(6, 2'b10, 32'd0, 1'b0);
    for (int c = 7; c <= 13; c++) exp_rd(c, 2'b10, 32'(14 - c), 1'b0);
    exp_rd(14, 2'b10, 32'd0, 1'b1);
    exp_rd(15, 2'b10, 32'd0, 1'b0);
    run(15);

    // PRESET=0 and PRESET=1 both reach INT three cycles after EN
    cur_test = "preset0";
    do_reset();
    wr(2'b01, 32'd0);
    wr(2'b00, 32'h9);
    exp_rd(1, 2'b10, 32'd0, 1'b0);
    exp_rd(2, 2'b10, 32'd0, 1'b0);
    exp_rd(3, 2'b10, 32'd0, 1'b1);
    exp_rd(4, 2'b00, 32'h8, 1'b1);
    run(4);
    cur_test = "preset1";
    do_reset();
    wr(2'b01, 32'd1);
    wr(2'b00, 32'h9);
    exp_rd(2, 2'b10, 32'd1, 1'b0);
    exp_rd(3, 2'b10, 32'd0, 1'b1);
    run(3);

    // Disable at COUNT=6: count holds 5, no flag set
    cur_test = "disable";
    do_reset();
    wr(2'b01, 32'd10);
    wr(2'b00, 32'h1);
    for (int c = 2; c <= 6; c++) exp_rd(c, 2'b10, 32'(12 - c), 1'b0);
    sched_wr(6, 2'b00, 32'h0);
    for (int c = 7; c <= 12; c++) exp_rd(c, 2'b10, 32'd5, 1'b0);
    exp_rd(8, 2'b00, 32'h0, 1'b0);
    sched_wr(9, 2'b10, 32'h0000_ABCD);
    sched_wr(11, 2'b00, 32'h8);
    exp_rd(12, 2'b00, 32'h8, 1'b0);
    run(12);

    // CTRL write in INT overrides the one-shot EN clear
    cur_test = "override";
    do_reset();
    wr(2'b01, 32'd2);
    wr(2'b00, 32'h9);
    exp_rd(4, 2'b00, 32'h9, 1'b1);
    sched_wr(4, 2'b00, 32'h9);
    exp_rd(5, 2'b00, 32'h9, 1'b0);
    exp_rd(6, 2'b10, 32'd0, 1'b0);
    exp_rd(7, 2'b10, 32'd2, 1'b0);
    exp_rd(8, 2'b10, 32'd1, 1'b0);
    exp_rd(9, 2'b10, 32'd0, 1'b1);
    run(9);

    // Reset pulsed at COUNT=4 aborts the count; no IRQ afterwards
    cur_test = "rst_mid";
    do_reset();
    wr(2'b01, 32'd8);
    wr(2'b00, 32'h9);
    for (int c = 2; c <= 6; c++) exp_rd(c, 2'b10, 32'(10 - c), 1'b0);
    run(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) rd($sformatf("rst_mid a%0d", a), 2'(a), 32'd0, 1'b0);
    for (int c = 1; c <= 20; c++) exp_rd(c, 2'b10, 32'd0, 1'b0);
    run(20);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
